// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared main-memory port arbiter between fetch (imem) and load/store (dmem)
module mem_port_arbiter #(
   parameter int DMEM_MAX_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_req,
   input  logic [31:0] imem_addr,
   output logic        imem_ready,
   output logic [31:0] imem_data,
   input  logic        dmem_req,
   input  logic        dmem_wr,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic        dmem_ready,
   output logic [31:0] dmem_data,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_wr,
   input  logic [31:0] mem_data_out,
   input  logic        mem_ready,
   output logic        timeout_err
);

   localparam int SW = $clog2(DMEM_MAX_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [SW-1:0] STREAK_MAX = SW'(DMEM_MAX_STREAK);
   localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT_CYCLES);
   localparam logic [31:0]   ABORT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_I,
      S_BUSY_D,
      S_DONE
   } state_t;

   state_t        state;
   logic [SW-1:0] streak;
   logic [TW-1:0] timer;

   logic          dmem_wins;
   logic [TW-1:0] timer_next;
   logic          timer_expired;

   // Dmem has priority unless fetch has been starved for the full streak allowance.
   always_comb begin
      dmem_wins     = dmem_req && !(imem_req && (streak == STREAK_MAX));
      timer_next    = timer + TW'(1);
      timer_expired = (TIMEOUT_CYCLES != 0) && (timer_next == TIMEOUT_V);
   end

   // Arbitration FSM with registered bus outputs, completion pulses and watchdog.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         streak      <= '0;
         timer       <= '0;
         imem_ready  <= 1'b0;
         imem_data   <= '0;
         dmem_ready  <= 1'b0;
         dmem_data   <= '0;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_wr      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         imem_ready <= 1'b0;
         dmem_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               timer <= '0;
               if (dmem_wins) begin
                  state       <= S_BUSY_D;
                  mem_valid   <= 1'b1;
                  mem_addr    <= dmem_addr;
                  mem_data_in <= dmem_wdata;
                  mem_wr      <= dmem_wr;
                  // Only grants taken while fetch waits count toward starvation.
                  if (!imem_req) begin
                     streak <= '0;
                  end else if (streak != STREAK_MAX) begin
                     streak <= streak + SW'(1);
                  end
               end else if (imem_req) begin
                  state     <= S_BUSY_I;
                  mem_valid <= 1'b1;
                  mem_addr  <= imem_addr;
                  mem_wr    <= 1'b0;
                  streak    <= '0;
               end
            end
            S_BUSY_I: begin
               timer <= timer_next;
               if (mem_ready) begin
                  imem_data  <= mem_data_out;
                  imem_ready <= 1'b1;
                  mem_valid  <= 1'b0;
                  mem_wr     <= 1'b0;
                  state      <= S_DONE;
               end else if (timer_expired) begin
                  imem_data   <= ABORT_DATA;
                  imem_ready  <= 1'b1;
                  timeout_err <= 1'b1;
                  mem_valid   <= 1'b0;
                  mem_wr      <= 1'b0;
                  state       <= S_DONE;
               end
            end
            S_BUSY_D: begin
               timer <= timer_next;
               // mem_wr is stable through BUSY, so it tells loads from stores here.
               if (mem_ready) begin
                  if (!mem_wr) begin
                     dmem_data <= mem_data_out;
                  end
                  dmem_ready <= 1'b1;
                  mem_valid  <= 1'b0;
                  mem_wr     <= 1'b0;
                  state      <= S_DONE;
               end else if (timer_expired) begin
                  if (!mem_wr) begin
                     dmem_data <= ABORT_DATA;
                  end
                  dmem_ready  <= 1'b1;
                  timeout_err <= 1'b1;
                  mem_valid   <= 1'b0;
                  mem_wr      <= 1'b0;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               timer <= '0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic        dmem_req;
   logic        dmem_wr;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_data;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic        mem_wr;
   logic [31:0] mem_data_out;
   logic        mem_ready;
   logic        timeout_err;

   logic        fixed_en;
   logic [31:0] fixed_rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign mem_data_out = fixed_en ? fixed_rdata : model_rd(mem_addr);

   mem_port_arbiter #(
      .DMEM_MAX_STREAK(4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_data   (imem_data),
      .dmem_req    (dmem_req),
      .dmem_wr     (dmem_wr),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ready  (dmem_ready),
      .dmem_data   (dmem_data),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_wr      (mem_wr),
      .mem_data_out(mem_data_out),
      .mem_ready   (mem_ready),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_d, input logic [31:0] d);
      exp_t e;
      e.is_d = is_d;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_valid"},   {31'd0, mem_valid},   32'd0);
      check({tag, "_mem_addr"},    mem_addr,             32'd0);
      check({tag, "_mem_data_in"}, mem_data_in,          32'd0);
      check({tag, "_mem_wr"},      {31'd0, mem_wr},      32'd0);
      check({tag, "_imem_ready"},  {31'd0, imem_ready},  32'd0);
      check({tag, "_dmem_ready"},  {31'd0, dmem_ready},  32'd0);
      check({tag, "_imem_data"},   imem_data,            32'd0);
      check({tag, "_dmem_data"},   dmem_data,            32'd0);
      check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
   endtask

   // Waits for the next completion pulse and checks it against the scoreboard front.
   task automatic wait_done(input string tag, input int max_cycles, output int busy);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      busy = 0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (imem_ready || dmem_ready) begin
            seen = 1'b1;
            check({tag, "_exclusive"}, {31'd0, imem_ready & dmem_ready}, 32'd0);
            check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check({tag, "_port"}, {30'd0, dmem_ready, imem_ready}, e.is_d ? 32'd2 : 32'd1);
               check({tag, "_data"}, e.is_d ? dmem_data : imem_data, e.data);
            end
         end else if (mem_valid) begin
            busy++;
         end
      end
      check({tag, "_completed"}, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int busy;
      int pulses;
      int vcnt;

      rst = 1'b0; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_wr = 1'b0;
      dmem_addr = '0; dmem_wdata = '0; mem_ready = 1'b0; fixed_en = 1'b0; fixed_rdata = '0;

      // Power-on reset
      @(negedge clk);
      @(negedge clk);
      check_all_zero("rst_init");
      rst = 1'b1;
      @(negedge clk);

      // Single fetch with exact latency
      imem_req = 1'b1; imem_addr = 32'h100; mem_ready = 1'b1;
      fixed_en = 1'b1; fixed_rdata = 32'h0050_0093;
      push(1'b0, 32'h0050_0093);
      @(negedge clk);
      check("t2_mem_valid", {31'd0, mem_valid}, 32'd1);
      check("t2_mem_addr", mem_addr, 32'h100);
      check("t2_no_early_ready", {31'd0, imem_ready}, 32'd0);
      wait_done("t2", 1, busy);
      imem_req = 1'b0; fixed_en = 1'b0;

      // Simultaneous requests: store wins, fetch follows
      @(negedge clk);
      dmem_req = 1'b1; dmem_wr = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'hCAFE_F00D;
      imem_req = 1'b1; imem_addr = 32'h104;
      push(1'b1, 32'h0);
      push(1'b0, model_rd(32'h104));
      @(negedge clk);
      check("t3_mem_valid", {31'd0, mem_valid}, 32'd1);
      check("t3_mem_wr", {31'd0, mem_wr}, 32'd1);
      check("t3_mem_addr", mem_addr, 32'h2000);
      check("t3_mem_data_in", mem_data_in, 32'hCAFE_F00D);
      wait_done("t3_d", 1, busy);
      dmem_req = 1'b0; dmem_wr = 1'b0;
      wait_done("t3_i", 4, busy);
      check("t3_i_busy", busy, 32'd1);
      imem_req = 1'b0;

      // Both held high: starvation limit forces D,D,D,D,I twice
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h400;
      dmem_req = 1'b1; dmem_wr = 1'b0; dmem_addr = 32'h800;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(1'b1, model_rd(32'h800));
         push(1'b0, model_rd(32'h400));
      end
      for (int i = 0; i < 10; i++) wait_done($sformatf("t4_grant%0d", i), 6, busy);
      imem_req = 1'b0; dmem_req = 1'b0;
      check("t4_no_timeout", {31'd0, timeout_err}, 32'd0);

      // mem_ready in IDLE is ignored; a dropped fetch still completes once
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      check("t6_idle_no_valid", {31'd0, mem_valid}, 32'd0);
      check("t6_idle_no_ready", {30'd0, dmem_ready, imem_ready}, 32'd0);
      mem_ready = 1'b0; imem_req = 1'b1; imem_addr = 32'h300;
      push(1'b0, model_rd(32'h300));
      @(negedge clk);
      check("t6_mem_valid", {31'd0, mem_valid}, 32'd1);
      check("t6_mem_addr", mem_addr, 32'h300);
      imem_req = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_still_busy", {31'd0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      wait_done("t6", 1, busy);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (imem_ready || dmem_ready) pulses++;
      end
      check("t6_single_pulse", pulses, 32'd0);

      // Watchdog abort on a hung load
      mem_ready = 1'b0; dmem_req = 1'b1; dmem_wr = 1'b0; dmem_addr = 32'hA00;
      push(1'b1, 32'hDEAD_BEEF);
      wait_done("t5", 20, busy);
      check("t5_busy_cycles", busy, 32'd8);
      check("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
      dmem_req = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);

      // Reset in the middle of a load
      dmem_req = 1'b1; dmem_wr = 1'b0; dmem_addr = 32'h900;
      @(negedge clk);
      check("t1_busy_d", {31'd0, mem_valid}, 32'd1);
      @(negedge clk);
      rst = 1'b0; dmem_req = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check_all_zero("t1_rst_a");
      @(negedge clk);
      check_all_zero("t1_rst_b");
      rst = 1'b1;
      pulses = 0;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dmem_ready || imem_ready) pulses++;
         if (mem_valid) vcnt++;
      end
      check("t1_no_ready_after", pulses, 32'd0);
      check("t1_idle_after", vcnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
